// File: rtl/sram_arbiter_pkg.sv
// Shared op codes, FSM states and request payload for the SRAM arbiter.
package sram_arbiter_pkg;

   localparam logic [7:0] MEM_NOP = 8'h00;
   localparam logic [7:0] MEM_LB  = 8'h01;
   localparam logic [7:0] MEM_LW  = 8'h02;
   localparam logic [7:0] MEM_SB  = 8'h03;
   localparam logic [7:0] MEM_SW  = 8'h04;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Accepted request: who asked, what op, which byte lane.
   typedef struct packed {
      logic       is_data;
      logic [7:0] op;
      logic [1:0] lane;
   } req_t;

   function automatic logic is_load(input logic [7:0] op);
      return (op == MEM_LB) || (op == MEM_LW);
   endfunction

   function automatic logic is_store(input logic [7:0] op);
      return (op == MEM_SB) || (op == MEM_SW);
   endfunction

   function automatic logic is_byte(input logic [7:0] op);
      return (op == MEM_LB) || (op == MEM_SB);
   endfunction

endpackage

// File: rtl/sram_arbiter_byte_lane_unit.sv
// Byte-lane helper: byte enables, SB store replication and LB sign extension.
module sram_arbiter_byte_lane_unit
   import sram_arbiter_pkg::*;
(
   input  logic [7:0]  op,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be_n,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [7:0] sel_byte;

   always_comb begin
      be_n      = 4'h0;
      wdata_rep = wdata;
      rdata_ext = rdata;
      sel_byte  = rdata[8 * lane +: 8];
      if (is_byte(op)) begin
         be_n = 4'(~(4'b0001 << lane));
      end
      if (op == MEM_SB) begin
         wdata_rep = {4{wdata[7:0]}};
      end
      if (op == MEM_LB) begin
         rdata_ext = {{24{sel_byte[7]}}, sel_byte};
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the single SRAM port between instruction fetch and data access,
// data first, sequencing each access as IDLE -> READ/WRITE -> DONE.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter int unsigned SRAM_AW       = 20
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               if_req,
   input  logic [31:0]        if_addr,
   output logic [31:0]        if_rdata,
   output logic               if_ack,
   input  logic [7:0]         mem_op,
   input  logic [31:0]        mem_addr,
   input  logic [31:0]        mem_wdata,
   output logic [31:0]        mem_rdata,
   output logic               mem_ack,
   output logic               stall_req,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [31:0]        sram_wdata,
   output logic               sram_wdata_oe,
   input  logic [31:0]        sram_rdata,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   output logic [3:0]         sram_be_n
);

   localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   req_t             req_q;

   logic        data_sel;
   logic [7:0]  accept_op;
   logic [31:0] accept_addr;
   logic [7:0]  lane_op;
   logic [1:0]  lane_sel;
   logic [3:0]  be_n_c;
   logic [31:0] wdata_rep_c;
   logic [31:0] rdata_ext_c;
   logic        unused_addr_bits;

   // Unrecognised data ops fall through to fetch arbitration as NOPs.
   assign data_sel    = is_load(mem_op) || is_store(mem_op);
   assign accept_op   = data_sel ? mem_op : MEM_LW;
   assign accept_addr = data_sel ? mem_addr : if_addr;

   // Lane unit sees the incoming request while idle, the latched one otherwise.
   assign lane_op  = (state == ST_IDLE) ? accept_op : req_q.op;
   assign lane_sel = (state == ST_IDLE) ? accept_addr[1:0] : req_q.lane;

   assign stall_req = (data_sel && !mem_ack) || (if_req && !if_ack);

   assign unused_addr_bits = ^{mem_addr[31:SRAM_AW+2], if_addr[31:SRAM_AW+2]};

   sram_arbiter_byte_lane_unit u_lane (
      .op        (lane_op),
      .lane      (lane_sel),
      .wdata     (mem_wdata),
      .rdata     (sram_rdata),
      .be_n      (be_n_c),
      .wdata_rep (wdata_rep_c),
      .rdata_ext (rdata_ext_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         req_q         <= '0;
         sram_addr     <= '0;
         sram_wdata    <= '0;
         sram_wdata_oe <= 1'b0;
         sram_ce_n     <= 1'b1;
         sram_oe_n     <= 1'b1;
         sram_we_n     <= 1'b1;
         sram_be_n     <= 4'hF;
         if_ack        <= 1'b0;
         mem_ack       <= 1'b0;
         if_rdata      <= '0;
         mem_rdata     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (data_sel || if_req) begin
                  req_q.is_data <= data_sel;
                  req_q.op      <= accept_op;
                  req_q.lane    <= accept_addr[1:0];
                  cnt           <= '0;
                  sram_addr     <= accept_addr[SRAM_AW+1:2];
                  sram_be_n     <= be_n_c;
                  sram_ce_n     <= 1'b0;
                  if (data_sel && is_store(mem_op)) begin
                     sram_we_n     <= 1'b0;
                     sram_wdata_oe <= 1'b1;
                     sram_wdata    <= wdata_rep_c;
                     state         <= ST_WRITE;
                  end else begin
                     sram_oe_n <= 1'b0;
                     state     <= ST_READ;
                  end
               end
            end

            ST_READ: begin
               if (cnt == CNT_LAST) begin
                  sram_ce_n <= 1'b1;
                  sram_oe_n <= 1'b1;
                  sram_be_n <= 4'hF;
                  state     <= ST_DONE;
                  if (req_q.is_data) begin
                     mem_rdata <= rdata_ext_c;
                     mem_ack   <= 1'b1;
                  end else begin
                     if_rdata <= sram_rdata;
                     if_ack   <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // Address and data stay on the bus through DONE as write hold time.
            ST_WRITE: begin
               if (cnt == CNT_LAST) begin
                  sram_ce_n <= 1'b1;
                  sram_we_n <= 1'b1;
                  sram_be_n <= 4'hF;
                  mem_ack   <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_DONE: begin
               if_ack        <= 1'b0;
               mem_ack       <= 1'b0;
               sram_wdata_oe <= 1'b0;
               state         <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic against a word-level memory model.
module tb_sram_arbiter;
   import sram_arbiter_pkg::*;

   localparam int unsigned AC = 2;
   localparam int unsigned AW = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req;
   logic [31:0]   if_addr;
   logic [31:0]   if_rdata;
   logic          if_ack;
   logic [7:0]    mem_op;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          mem_ack;
   logic          stall_req;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_wdata;
   logic          sram_wdata_oe;
   logic [31:0]   sram_rdata;
   logic          sram_ce_n;
   logic          sram_oe_n;
   logic          sram_we_n;
   logic [3:0]    sram_be_n;

   int total = 0;
   int bad   = 0;

   logic [31:0] sram_mem [16];
   logic [31:0] ref_mem  [16];
   logic [31:0] exp_if;
   logic [31:0] exp_mem;

   always #5 clk = ~clk;

   sram_arbiter #(.ACCESS_CYCLES(AC), .SRAM_AW(AW)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_req(stall_req),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe),
      .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
   );

   // Asynchronous SRAM device: garbage unless both strobes are active.
   assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[3:0]] : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (!sram_ce_n && !sram_we_n && sram_wdata_oe) begin
         for (int k = 0; k < 4; k++) begin
            if (!sram_be_n[k]) sram_mem[sram_addr[3:0]][8*k +: 8] <= sram_wdata[8*k +: 8];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ce"}, 32'(sram_ce_n), 32'd1);
      chk({tag, "_oe"}, 32'(sram_oe_n), 32'd1);
      chk({tag, "_we"}, 32'(sram_we_n), 32'd1);
      chk({tag, "_ifack"}, 32'(if_ack), 32'd0);
      chk({tag, "_memack"}, 32'(mem_ack), 32'd0);
   endtask

   // One complete access; op == MEM_NOP means an instruction fetch.
   task automatic xfer(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd);
      bit          fetch, store, byte_op;
      int          w, lane;
      logic [19:0] exp_wa;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd, exp_rd;
      logic [7:0]  b;
      fetch   = (op == MEM_NOP);
      store   = (op == MEM_SB) || (op == MEM_SW);
      byte_op = (op == MEM_LB) || (op == MEM_SB);
      w       = int'(addr[5:2]);
      lane    = int'(addr[1:0]);
      exp_wa  = addr[21:2];
      exp_be  = byte_op ? 4'(~(4'b0001 << lane)) : 4'h0;
      exp_wd  = (op == MEM_SB) ? {4{wd[7:0]}} : wd;
      b       = ref_mem[w][8*lane +: 8];
      exp_rd  = (op == MEM_LB) ? {{24{b[7]}}, b} : ref_mem[w];

      if (fetch) begin
         if_req = 1'b1; if_addr = addr;
      end else begin
         mem_op = op; mem_addr = addr; mem_wdata = wd;
      end
      #1 chk("stall_req_start", 32'(stall_req), 32'd1);

      for (int n = 1; n <= int'(AC) + 1; n++) begin
         @(posedge clk); #1;
         if (n <= int'(AC)) begin
            chk("strobe_ce", 32'(sram_ce_n), 32'd0);
            chk("strobe_oe", 32'(sram_oe_n), store ? 32'd1 : 32'd0);
            chk("strobe_we", 32'(sram_we_n), store ? 32'd0 : 32'd1);
            chk("strobe_be", 32'(sram_be_n), 32'(exp_be));
            chk("strobe_addr", 32'(sram_addr), 32'(exp_wa));
            if (store) begin
               chk("strobe_wdata", sram_wdata, exp_wd);
               chk("strobe_wdata_oe", 32'(sram_wdata_oe), 32'd1);
            end
            chk("early_if_ack", 32'(if_ack), 32'd0);
            chk("early_mem_ack", 32'(mem_ack), 32'd0);
            chk("stall_busy", 32'(stall_req), 32'd1);
         end else begin
            chk("done_ce", 32'(sram_ce_n), 32'd1);
            chk("done_oe", 32'(sram_oe_n), 32'd1);
            chk("done_we", 32'(sram_we_n), 32'd1);
            chk("done_be", 32'(sram_be_n), 32'hF);
            if (fetch) begin
               exp_if = exp_rd;
               chk("if_ack", 32'(if_ack), 32'd1);
               chk("if_ack_memack", 32'(mem_ack), 32'd0);
            end else begin
               if (!store) exp_mem = exp_rd;
               chk("mem_ack", 32'(mem_ack), 32'd1);
               chk("mem_ack_ifack", 32'(if_ack), 32'd0);
            end
            if (store) begin
               chk("hold_addr", 32'(sram_addr), 32'(exp_wa));
               chk("hold_wdata", sram_wdata, exp_wd);
            end
            chk("if_rdata", if_rdata, exp_if);
            chk("mem_rdata", mem_rdata, exp_mem);
            chk("stall_ack", 32'(stall_req), 32'd0);
         end
      end

      if (op == MEM_SW) ref_mem[w] = wd;
      if (op == MEM_SB) ref_mem[w][8*lane +: 8] = wd[7:0];
      if_req = 1'b0; mem_op = MEM_NOP;
      @(posedge clk); #1;
      chk_quiet("after_done");
   endtask

   initial begin
      logic [31:0] r, d;
      logic [7:0]  rop;
      rst = 1'b1; if_req = 1'b0; if_addr = '0;
      mem_op = MEM_NOP; mem_addr = '0; mem_wdata = '0;
      exp_if = '0; exp_mem = '0;
      for (int i = 0; i < 16; i++) begin
         d = $urandom();
         sram_mem[i] = d; ref_mem[i] = d;
      end
      sram_mem[0] = 32'h1122_3344; ref_mem[0] = 32'h1122_3344;
      sram_mem[1] = 32'h1280_3456; ref_mem[1] = 32'h1280_3456;
      sram_mem[4] = 32'h2402_0005; ref_mem[4] = 32'h2402_0005;

      // Reset values.
      repeat (2) @(posedge clk);
      #1;
      chk_quiet("reset");
      chk("reset_be", 32'(sram_be_n), 32'hF);
      chk("reset_addr", 32'(sram_addr), 32'd0);
      chk("reset_wdata", sram_wdata, 32'd0);
      chk("reset_wdata_oe", 32'(sram_wdata_oe), 32'd0);
      chk("reset_if_rdata", if_rdata, 32'd0);
      chk("reset_mem_rdata", mem_rdata, 32'd0);
      rst = 1'b0;

      // Reset in the first READ cycle drops the fetch.
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h0000_0010;
      @(posedge clk); #1;
      chk("midread_ce", 32'(sram_ce_n), 32'd0);
      rst = 1'b1;
      #1;
      chk_quiet("midread_rst");
      chk("midread_be", 32'(sram_be_n), 32'hF);
      chk("midread_addr", 32'(sram_addr), 32'd0);
      if_req = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk_quiet("held_rst");
      end
      rst = 1'b0;
      @(posedge clk); #1;
      chk_quiet("post_rst");
      chk("post_rst_if_rdata", if_rdata, 32'd0);

      // Directed accesses.
      xfer(MEM_NOP, 32'h8000_0010, 32'h0);
      chk("fetch_word4", if_rdata, 32'h2402_0005);
      xfer(MEM_LB, 32'h0000_0006, 32'h0);
      chk("lb_signext", mem_rdata, 32'hFFFF_FF80);
      xfer(MEM_SB, 32'h0000_0003, 32'h0000_00A5);
      chk("sb_keeps_mem_rdata", mem_rdata, 32'hFFFF_FF80);
      xfer(MEM_LW, 32'h0000_0000, 32'h0);
      chk("lw_after_sb", mem_rdata, 32'hA522_3344);

      // Contention: store wins, fetch follows after DONE.
      if_req = 1'b1; if_addr = 32'h0000_0010;
      mem_op = MEM_SW; mem_addr = 32'h0000_0020; mem_wdata = 32'hCAFE_F00D;
      for (int n = 1; n <= 7; n++) begin
         @(posedge clk); #1;
         chk("cont_mem_ack", 32'(mem_ack), (n == 3) ? 32'd1 : 32'd0);
         chk("cont_if_ack", 32'(if_ack), (n == 7) ? 32'd1 : 32'd0);
         chk("cont_we", 32'(sram_we_n), (n <= 2) ? 32'd0 : 32'd1);
         chk("cont_oe", 32'(sram_oe_n), (n == 5 || n == 6) ? 32'd0 : 32'd1);
         chk("cont_stall", 32'(stall_req), (n == 7) ? 32'd0 : 32'd1);
         if (n == 3) begin
            mem_op = MEM_NOP;
            ref_mem[8] = 32'hCAFE_F00D;
         end
      end
      chk("cont_if_rdata", if_rdata, ref_mem[4]);
      exp_if = ref_mem[4];
      if_req = 1'b0;
      @(posedge clk); #1;

      // Idle, including an unrecognised op.
      for (int n = 0; n < 10; n++) begin
         if (n == 5) mem_op = 8'h07;
         @(posedge clk); #1;
         chk_quiet("idle");
         if (n < 5) chk("idle_stall", 32'(stall_req), 32'd0);
      end
      mem_op = MEM_NOP;
      @(posedge clk); #1;

      // Random traffic with wrap-around upper address bits.
      for (int i = 0; i < 40; i++) begin
         r = $urandom();
         d = $urandom();
         case ($urandom_range(0, 4))
            0: rop = MEM_NOP;
            1: rop = MEM_LB;
            2: rop = MEM_LW;
            3: rop = MEM_SB;
            default: rop = MEM_SW;
         endcase
         xfer(rop, {r[31:22], 16'h0, r[5:0]}, d);
      end
      for (int i = 0; i < 16; i++) xfer(MEM_LW, 32'(i * 4), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
